fsm_input_conditioner: RTL and testbench

Input conditioning stage that sits directly upstream of the lab control FSM and drives its `x1`, `x2`, `x3` inputs. It takes three raw, asynchronous, possibly bouncing signals, such as switches or push-buttons. Each signal passes through a two-flop synchronizer and a per-channel stability counter. The block presents clean, registered levels that change only after a configurable number of consecutive stable cycles. A one-cycle `changed` strobe and a `stable` flag are provided for debug LEDs and testbench checking.

---
 rtl/fsm_input_conditioner.sv | 74 +++++++
 tb/tb_fsm_input_conditioner.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/fsm_input_conditioner.sv
// Three-channel input conditioner: two-flop synchronizer plus a stability
// counter per channel, presenting clean registered levels to the lab FSM.
module fsm_input_conditioner #(
  parameter int DEBOUNCE = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_x1,
  input  logic raw_x2,
  input  logic raw_x3,
  output logic x1,
  output logic x2,
  output logic x3,
  output logic changed,
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE - 1);

  logic [2:0]       raw;
  logic [2:0]       sync_p0;
  logic [2:0]       sync_p1;
  logic [2:0]       lvl_p2;
  logic [2:0]       lvl_nxt;
  logic [2:0]       upd;
  logic [2:0]       chan_ok;
  logic [CNT_W-1:0] cnt_p2  [3];
  logic [CNT_W-1:0] cnt_nxt [3];

  assign raw = {raw_x3, raw_x2, raw_x1};

  // Per channel: exactly one of clear / commit / count on every edge.
  always_comb begin
    lvl_nxt = lvl_p2;
    upd     = '0;
    chan_ok = '0;
    for (int i = 0; i < 3; i++) begin
      cnt_nxt[i] = '0;
      chan_ok[i] = (sync_p1[i] == lvl_p2[i]) && (cnt_p2[i] == '0);
      if (sync_p1[i] != lvl_p2[i]) begin
        if (cnt_p2[i] == CNT_MAX) begin
          lvl_nxt[i] = sync_p1[i];
          upd[i]     = 1'b1;
        end else begin
          cnt_nxt[i] = cnt_p2[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stage p0/p1: synchronizer; stage p2: debounced level, counter, strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
      lvl_p2  <= '0;
      changed <= 1'b0;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
      lvl_p2  <= lvl_nxt;
      changed <= |upd;
      for (int i = 0; i < 3; i++) cnt_p2[i] <= cnt_nxt[i];
    end
  end

  assign stable = &chan_ok;
  assign x1     = lvl_p2[0];
  assign x2     = lvl_p2[1];
  assign x3     = lvl_p2[2];

endmodule

// File: tb/tb_fsm_input_conditioner.sv
// Directed bench for fsm_input_conditioner: DEBOUNCE=8 instance for the main
// sequences and a DEBOUNCE=1 instance for the unfiltered pass-through case.
module tb_fsm_input_conditioner;

  logic clk = 1'b0;
  logic reset;
  logic raw_x1, raw_x2, raw_x3;
  logic x1, x2, x3, changed, stable;
  logic d1_raw_x1, d1_raw_x2, d1_raw_x3;
  logic d1_x1, d1_x2, d1_x3, d1_changed, d1_stable;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  fsm_input_conditioner #(.DEBOUNCE(8), .CNT_W(4)) dut (
    .clk(clk), .reset(reset),
    .raw_x1(raw_x1), .raw_x2(raw_x2), .raw_x3(raw_x3),
    .x1(x1), .x2(x2), .x3(x3), .changed(changed), .stable(stable)
  );

  fsm_input_conditioner #(.DEBOUNCE(1), .CNT_W(1)) dut1 (
    .clk(clk), .reset(reset),
    .raw_x1(d1_raw_x1), .raw_x2(d1_raw_x2), .raw_x3(d1_raw_x3),
    .x1(d1_x1), .x2(d1_x2), .x3(d1_x3), .changed(d1_changed), .stable(d1_stable)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Advance n rising edges, leaving the bench 1 time unit past the last edge.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  logic [15:0] bounce_pat;

  initial begin
    reset = 1'b1;
    raw_x1 = 1'b1; raw_x2 = 1'b1; raw_x3 = 1'b1;
    d1_raw_x1 = 1'b0; d1_raw_x2 = 1'b0; d1_raw_x3 = 1'b0;

    // Reset held with raw inputs high
    step(3);
    chk("rst_x", {1'b0, x3, x2, x1}, 4'h0);
    chk("rst_changed", {3'b0, changed}, 4'h0);
    chk("rst_stable", {3'b0, stable}, 4'h1);
    chk("rst_d1_x", {1'b0, d1_x3, d1_x2, d1_x1}, 4'h0);
    reset = 1'b0;
    step(3);
    chk("rel_unstable", {3'b0, stable}, 4'h0);
    step(6);
    chk("rel_edge9_x", {changed, x3, x2, x1}, 4'h0);
    step(1);
    chk("rel_edge10_x", {changed, x3, x2, x1}, 4'hF);
    step(1);
    chk("rel_after_pulse", {changed, x3, x2, x1}, 4'h7);
    chk("rel_stable", {3'b0, stable}, 4'h1);

    // Return all channels to 0
    raw_x1 = 1'b0; raw_x2 = 1'b0; raw_x3 = 1'b0;
    step(10);
    chk("fall_x", {changed, x3, x2, x1}, 4'h8);
    step(2);
    chk("fall_stable", {changed, 2'b0, stable}, 4'h1);

    // Clean step on x2
    raw_x2 = 1'b1;
    step(1);
    step(8);
    chk("step_k8", {changed, x3, x2, x1}, 4'h0);
    step(1);
    chk("step_k9", {changed, x3, x2, x1}, 4'hA);
    step(1);
    chk("step_k10", {changed, x3, x2, x1}, 4'h2);
    chk("step_stable", {3'b0, stable}, 4'h1);

    // Bounce on x1: 7 high, 1 low, 7 high, then low
    bounce_pat = 16'b0111_1111_0111_1111;
    for (int i = 0; i < 16; i++) begin
      raw_x1 = bounce_pat[i];
      step(1);
      chk("bounce", {changed, x3, x2, x1}, 4'h2);
    end
    raw_x1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      chk("bounce_tail", {changed, x3, x2, x1}, 4'h2);
    end
    chk("bounce_stable", {3'b0, stable}, 4'h1);

    // x1 and x3 rise together; x2 falls one cycle later
    raw_x1 = 1'b1; raw_x3 = 1'b1;
    step(1);
    raw_x2 = 1'b0;
    step(8);
    chk("sim_k8", {changed, x3, x2, x1}, 4'h2);
    step(1);
    chk("sim_k9", {changed, x3, x2, x1}, 4'hF);
    step(1);
    chk("sim_k10", {changed, x3, x2, x1}, 4'hD);
    step(1);
    chk("sim_k11", {changed, x3, x2, x1}, 4'h5);
    chk("sim_stable", {3'b0, stable}, 4'h1);

    // Reset mid-count on x3 (x1 held high through reset as well)
    raw_x3 = 1'b0;
    step(11);
    chk("pre_mid", {changed, x3, x2, x1}, 4'h1);
    raw_x3 = 1'b1;
    step(7);
    chk("mid_cnt5", {stable, x3, x2, x1}, 4'h1);
    reset = 1'b1;
    step(1);
    chk("mid_rst_x", {changed, x3, x2, x1}, 4'h0);
    chk("mid_rst_stable", {3'b0, stable}, 4'h1);
    reset = 1'b0;
    step(9);
    chk("mid_rel9", {changed, x3, x2, x1}, 4'h0);
    step(1);
    chk("mid_rel10", {changed, x3, x2, x1}, 4'hD);
    step(1);
    chk("mid_rel11", {changed, x3, x2, x1}, 4'h5);

    // DEBOUNCE=1: one-cycle raw pulse emerges as one-cycle level pulse
    d1_raw_x1 = 1'b1;
    step(1);
    d1_raw_x1 = 1'b0;
    chk("d1_e1", {d1_changed, d1_x3, d1_x2, d1_x1}, 4'h0);
    step(1);
    chk("d1_e2", {d1_changed, d1_x3, d1_x2, d1_x1}, 4'h0);
    step(1);
    chk("d1_e3", {d1_changed, d1_x3, d1_x2, d1_x1}, 4'h9);
    step(1);
    chk("d1_e4", {d1_changed, d1_x3, d1_x2, d1_x1}, 4'h8);
    step(1);
    chk("d1_e5", {d1_changed, d1_x3, d1_x2, d1_x1}, 4'h0);
    chk("d1_stable", {3'b0, d1_stable}, 4'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
